display_scheduler: RTL and testbench

DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

---
 rtl/display_sched_pkg.sv | 27 ++
 rtl/hex7seg.sv | 31 +++
 rtl/display_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_display_scheduler.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_sched_pkg.sv
// Shared encodings for the display scheduler: FSM states, register map, page ids.
package display_sched_pkg;

    typedef enum logic [1:0] {
        ST_ROTATE = 2'd0,
        ST_MANUAL = 2'd1,
        ST_ALERT  = 2'd2
    } state_e;

    localparam logic [1:0] ADDR_VALUE  = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;

    localparam logic [1:0] PAGE_LO   = 2'd0;
    localparam logic [1:0] PAGE_HI   = 2'd1;
    localparam logic [1:0] PAGE_STAT = 2'd2;

    // PAGE_SEL=3 has no page of its own and aliases the status page
    function automatic logic [1:0] sel_to_page(input logic [1:0] sel);
        return (sel == 2'd3) ? PAGE_STAT : sel;
    endfunction

    function automatic logic [1:0] next_page(input logic [1:0] p);
        return (p == PAGE_LO) ? PAGE_HI : ((p == PAGE_HI) ? PAGE_STAT : PAGE_LO);
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module hex7seg (
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_n_o
);

    // Combinational font lookup
    always_comb begin
        seg_n_o = 7'h7F;
        case (nibble_i)
            4'h0: seg_n_o = 7'h40;
            4'h1: seg_n_o = 7'h79;
            4'h2: seg_n_o = 7'h24;
            4'h3: seg_n_o = 7'h30;
            4'h4: seg_n_o = 7'h19;
            4'h5: seg_n_o = 7'h12;
            4'h6: seg_n_o = 7'h02;
            4'h7: seg_n_o = 7'h78;
            4'h8: seg_n_o = 7'h00;
            4'h9: seg_n_o = 7'h10;
            4'hA: seg_n_o = 7'h08;
            4'hB: seg_n_o = 7'h03;
            4'hC: seg_n_o = 7'h46;
            4'hD: seg_n_o = 7'h21;
            4'hE: seg_n_o = 7'h06;
            4'hF: seg_n_o = 7'h0E;
            default: seg_n_o = 7'h7F;
        endcase
    end

endmodule

// File: rtl/display_scheduler.sv
// Four-digit page scheduler with Avalon-MM register access, timed page rotation,
// manual page select and alert override.
// Define DISPLAY_SCHED_BLANK_EN to blank leading zero digits on hex3..hex1.
module display_scheduler
    import display_sched_pkg::*;
#(
    parameter logic [23:0] DWELL_DEFAULT = 24'd5000000,
    parameter int unsigned ALERT_PERIODS = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [15:0] hw_status,
    input  logic        hw_alert,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [3:0]  dp_n
);

    localparam logic [15:0] ALERT_LOAD = 16'(ALERT_PERIODS);

    logic        wr_en, ctrl_wr, tick;
    logic [31:0] value_q, value_d;
    logic        auto_q, auto_d;
    logic [1:0]  page_sel_q, page_sel_d;
    logic [23:0] dwell_q, dwell_d;
    logic [23:0] cnt_q, cnt_d;
    state_e      state_q, state_d;
    logic [1:0]  page_q, page_d;
    logic [15:0] acnt_q, acnt_d;
    logic [15:0] disp_word;
    logic [6:0]  seg [4];
    logic [6:0]  hex_q [4];
    logic [6:0]  hex_d [4];
    logic [3:0]  dp_n_q, dp_n_d;
    logic        unused_ctrl_bits;

    assign wr_en            = chipselect && !write_n;
    assign ctrl_wr          = wr_en && (address == ADDR_CTRL);
    assign tick             = (cnt_q == '0);
    assign unused_ctrl_bits = ^writedata[7:3];

    // Register file next-state from bus writes
    always_comb begin
        value_d    = value_q;
        auto_d     = auto_q;
        page_sel_d = page_sel_q;
        dwell_d    = dwell_q;
        if (wr_en && address == ADDR_VALUE) value_d = writedata;
        if (ctrl_wr) begin
            auto_d     = writedata[0];
            page_sel_d = writedata[2:1];
            dwell_d    = writedata[31:8];
        end
    end

    // Dwell down counter: reloads on reaching zero or on any CTRL write
    always_comb begin
        if (ctrl_wr)   cnt_d = writedata[31:8];
        else if (tick) cnt_d = dwell_q;
        else           cnt_d = cnt_q - 24'd1;
    end

    // Page FSM next-state; an alert pulse overrides everything, including a same-cycle CTRL write
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        acnt_d  = acnt_q;
        if (hw_alert) begin
            state_d = ST_ALERT;
            page_d  = PAGE_STAT;
            acnt_d  = ALERT_LOAD;
        end else begin
            case (state_q)
                ST_ROTATE: begin
                    if (!auto_q) begin
                        state_d = ST_MANUAL;
                        page_d  = sel_to_page(page_sel_q);
                    end else if (tick) begin
                        page_d = next_page(page_q);
                    end
                end
                ST_MANUAL: begin
                    if (auto_q) state_d = ST_ROTATE;
                    else        page_d  = sel_to_page(page_sel_q);
                end
                ST_ALERT: begin
                    page_d = PAGE_STAT;
                    if (tick) begin
                        if (acnt_q <= 16'd1) begin
                            acnt_d  = '0;
                            state_d = auto_q ? ST_ROTATE : ST_MANUAL;
                            page_d  = auto_q ? PAGE_LO : sel_to_page(page_sel_q);
                        end else begin
                            acnt_d = acnt_q - 16'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_ROTATE;
                    page_d  = PAGE_LO;
                end
            endcase
        end
    end

    // Registers, counters and FSM state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q    <= '0;
            auto_q     <= 1'b1;
            page_sel_q <= '0;
            dwell_q    <= DWELL_DEFAULT;
            cnt_q      <= DWELL_DEFAULT;
            state_q    <= ST_ROTATE;
            page_q     <= PAGE_LO;
            acnt_q     <= '0;
        end else begin
            value_q    <= value_d;
            auto_q     <= auto_d;
            page_sel_q <= page_sel_d;
            dwell_q    <= dwell_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            page_q     <= page_d;
            acnt_q     <= acnt_d;
        end
    end

    // Source word for the currently displayed page
    always_comb begin
        case (page_q)
            PAGE_LO: disp_word = value_q[15:0];
            PAGE_HI: disp_word = value_q[31:16];
            default: disp_word = hw_status;
        endcase
    end

    hex7seg u_hex0 (.nibble_i(disp_word[3:0]),   .seg_n_o(seg[0]));
    hex7seg u_hex1 (.nibble_i(disp_word[7:4]),   .seg_n_o(seg[1]));
    hex7seg u_hex2 (.nibble_i(disp_word[11:8]),  .seg_n_o(seg[2]));
    hex7seg u_hex3 (.nibble_i(disp_word[15:12]), .seg_n_o(seg[3]));

    // Digit patterns and page indicator ahead of the output registers
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) hex_d[i] = seg[i];
`ifdef DISPLAY_SCHED_BLANK_EN
        if (disp_word[15:12] == '0) hex_d[3] = '1;
        if (disp_word[15:8]  == '0) hex_d[2] = '1;
        if (disp_word[15:4]  == '0) hex_d[1] = '1;
`endif
        dp_n_d = ~(4'b0001 << page_q);
    end

    // Registered display outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 4; i++) hex_q[i] <= 7'b1000000;
            dp_n_q <= 4'b1110;
        end else begin
            for (int unsigned i = 0; i < 4; i++) hex_q[i] <= hex_d[i];
            dp_n_q <= dp_n_d;
        end
    end

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign dp_n = dp_n_q;

    // Zero-wait-state read mux
    always_comb begin
        case (address)
            ADDR_VALUE:  readdata = value_q;
            ADDR_CTRL:   readdata = {dwell_q, 5'b0, page_sel_q, auto_q};
            ADDR_STATUS: readdata = {hw_status, 12'h000, state_q, page_q};
            default:     readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler: register vector table, directed
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_display_scheduler;

    localparam int AP = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [15:0] hw_status = 16'hA5A5;
    logic        hw_alert = 1'b0;
    logic [6:0]  hex0, hex1, hex2, hex3;
    logic [3:0]  dp_n;

    int total = 0;
    int bad = 0;

    display_scheduler #(.DWELL_DEFAULT(24'd5000000), .ALERT_PERIODS(AP)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .hw_status(hw_status), .hw_alert(hw_alert),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .dp_n(dp_n)
    );

    always #5 clk = ~clk;

    logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Behavioural model: mode 0=rotate 1=manual 2=alert
    logic [31:0] m_value;
    int          m_auto, m_sel, m_dwell, m_cnt, m_mode, m_page, m_rem;
    logic [6:0]  m_hex [4];
    logic [3:0]  m_dp;

    function automatic int sel_page(int s);
        return (s == 3) ? 2 : s;
    endfunction

    task automatic model_reset();
        m_value = 0; m_auto = 1; m_sel = 0; m_dwell = 5000000; m_cnt = 5000000;
        m_mode = 0; m_page = 0; m_rem = 0;
        for (int d = 0; d < 4; d++) m_hex[d] = 7'h40;
        m_dp = 4'b1110;
    endtask

    task automatic model_step();
        int tick, wr, n_mode, n_page, n_rem, n_cnt;
        logic [15:0] w;
        tick = (m_cnt == 0);
        wr = chipselect && !write_n;
        w = (m_page == 0) ? m_value[15:0] : (m_page == 1) ? m_value[31:16] : hw_status;
        for (int d = 0; d < 4; d++) begin
            m_hex[d] = font[(w >> (4 * d)) & 16'hF];
`ifdef DISPLAY_SCHED_BLANK_EN
            if (d > 0 && (w >> (4 * d)) == 0) m_hex[d] = 7'h7F;
`endif
        end
        m_dp = 4'hF & ~(4'b0001 << m_page);
        if (wr && address == 2'd1) n_cnt = int'(writedata[31:8]);
        else if (tick)             n_cnt = m_dwell;
        else                       n_cnt = m_cnt - 1;
        n_mode = m_mode; n_page = m_page; n_rem = m_rem;
        if (hw_alert) begin
            n_mode = 2; n_page = 2; n_rem = AP;
        end else if (m_mode == 0) begin
            if (m_auto == 0) begin n_mode = 1; n_page = sel_page(m_sel); end
            else if (tick) n_page = (m_page + 1) % 3;
        end else if (m_mode == 1) begin
            if (m_auto == 1) n_mode = 0;
            else n_page = sel_page(m_sel);
        end else if (tick) begin
            n_rem = m_rem - 1;
            if (n_rem <= 0) begin
                n_rem = 0;
                n_mode = m_auto ? 0 : 1;
                n_page = m_auto ? 0 : sel_page(m_sel);
            end
        end
        m_mode = n_mode; m_page = n_page; m_rem = n_rem; m_cnt = n_cnt;
        if (wr && address == 2'd0) m_value = writedata;
        if (wr && address == 2'd1) begin
            m_auto = writedata[0]; m_sel = writedata[2:1]; m_dwell = int'(writedata[31:8]);
        end
    endtask

    function automatic logic [31:0] model_read(logic [1:0] a);
        case (a)
            2'd0: return m_value;
            2'd1: return {m_dwell[23:0], 5'b0, m_sel[1:0], m_auto[0]};
            2'd2: return {hw_status, 12'h000, m_mode[1:0], m_page[1:0]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, got, exp, $time);
        end
    endtask

    // One clock: advance model, let the edge pass, compare everything against the model
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("outputs", {hex3, hex2, hex1, hex0, dp_n}, {m_hex[3], m_hex[2], m_hex[1], m_hex[0], m_dp});
        chk("readdata", readdata, model_read(address));
    endtask

    task automatic bus_wr(logic [1:0] a, logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        cyc();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic alert_duration(output int dur);
        logic [31:0] s;
        dur = 0;
        rd(2'd2, s);
        while (s[3:2] == 2'd2 && dur < 40) begin
            dur++;
            cyc();
            rd(2'd2, s);
        end
    endtask

    typedef struct {
        logic        cs;
        logic        wn;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    initial begin
        vec_t tbl[8];
        logic [31:0] r;
        int dur;
        logic [6:0] e3, e2, e1;

        tbl[0] = '{1'b1, 1'b0, 2'd0, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[1] = '{1'b1, 1'b0, 2'd1, 32'hFFFFFFFF, 32'hFFFFFF07};
        tbl[2] = '{1'b1, 1'b0, 2'd3, 32'h12345678, 32'h00000000};
        tbl[3] = '{1'b1, 1'b0, 2'd2, 32'hFFFFFFFF, 32'hA5A50000};
        tbl[4] = '{1'b0, 1'b0, 2'd0, 32'h00000000, 32'hDEADBEEF};
        tbl[5] = '{1'b1, 1'b1, 2'd1, 32'h00000000, 32'hFFFFFF07};
        tbl[6] = '{1'b0, 1'b1, 2'd0, 32'h11111111, 32'hDEADBEEF};
        tbl[7] = '{1'b1, 1'b0, 2'd1, 32'h4C4B4001, 32'h4C4B4001};

        // Reset state
        model_reset();
        #11;
        chk("rst_hex", {hex3, hex2, hex1, hex0}, {4'h0, 7'h40, 7'h40, 7'h40, 7'h40});
        chk("rst_dp", {28'h0, dp_n}, 32'h0000000E);
        rd(2'd1, r); chk("rst_ctrl", r, 32'h4C4B4001);
        rd(2'd0, r); chk("rst_value", r, 32'h0);
        rd(2'd2, r); chk("rst_status", r, 32'hA5A50000);
        reset_n = 1'b1;

        // Register access table
        for (int i = 0; i < 8; i++) begin
            address = tbl[i].addr; chipselect = tbl[i].cs;
            write_n = tbl[i].wn; writedata = tbl[i].wd;
            cyc();
            chipselect = 1'b0; write_n = 1'b1;
            chk($sformatf("tbl%0d", i), readdata, tbl[i].exp);
        end

        // Rotation with DWELL=3
        bus_wr(2'd0, 32'h1234ABCD);
        bus_wr(2'd1, 32'h00000301);
        chk("rot_p0", {hex3, hex2, hex1, hex0, dp_n}, {7'h08, 7'h03, 7'h46, 7'h21, 4'b1110});
        run(5);
        chk("rot_p1", {hex3, hex2, hex1, hex0, dp_n}, {7'h79, 7'h24, 7'h30, 7'h19, 4'b1101});
        run(4);
        chk("rot_p2", {hex3, hex2, hex1, hex0, dp_n}, {7'h08, 7'h12, 7'h08, 7'h12, 4'b1011});

        // Manual page 1 held
        bus_wr(2'd1, 32'h00000002);
        run(10);
        rd(2'd2, r); chk("man_status", {28'h0, r[3:0]}, 32'h5);
        chk("man_hex", {hex3, hex2, hex1, hex0, dp_n}, {7'h79, 7'h24, 7'h30, 7'h19, 4'b1101});
        run(40);
        chk("man_hold", {28'h0, dp_n}, 32'hD);

        // Leading zeros on manual page 0
        bus_wr(2'd0, 32'h00000005);
        bus_wr(2'd1, 32'h00000000);
        run(3);
`ifdef DISPLAY_SCHED_BLANK_EN
        e3 = 7'h7F; e2 = 7'h7F; e1 = 7'h7F;
`else
        e3 = 7'h40; e2 = 7'h40; e1 = 7'h40;
`endif
        chk("zeros", {4'h0, hex3, hex2, hex1, hex0}, {4'h0, e3, e2, e1, 7'h12});

        // Alert with DWELL=1 in rotate
        bus_wr(2'd1, 32'h00000101);
        run(3);
        hw_alert = 1'b1; cyc(); hw_alert = 1'b0;
        alert_duration(dur);
        chk("alert_len", 32'(dur >= 2 * AP - 1 && dur <= 2 * AP), 32'h1);
        rd(2'd2, r); chk("alert_exit", {28'h0, r[3:0]}, 32'h0);
        // Second pulse mid-alert restarts the full period count
        hw_alert = 1'b1; cyc(); hw_alert = 1'b0;
        run(3);
        hw_alert = 1'b1; cyc(); hw_alert = 1'b0;
        alert_duration(dur);
        chk("alert_ext", 32'(dur >= 2 * AP - 1 && dur <= 2 * AP), 32'h1);
        rd(2'd2, r); chk("ext_exit", {28'h0, r[3:0]}, 32'h0);

        // Alert coincident with CTRL write
        hw_alert = 1'b1;
        bus_wr(2'd1, 32'h00000503);
        hw_alert = 1'b0;
        rd(2'd2, r); chk("coinc_state", {30'h0, r[3:2]}, 32'h2);
        rd(2'd1, r); chk("coinc_ctrl", r, 32'h00000503);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            address    = 2'($urandom_range(0, 3));
            chipselect = ($urandom_range(0, 3) == 0);
            write_n    = 1'($urandom_range(0, 1));
            writedata  = (address == 2'd1) ? {24'($urandom_range(0, 3)), 8'($urandom)} : $urandom;
            hw_alert   = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 7) == 0) hw_status = 16'($urandom);
            cyc();
        end
        chipselect = 1'b0; write_n = 1'b1; hw_alert = 1'b0;

        // Reset mid-alert abandons it
        hw_alert = 1'b1; cyc(); hw_alert = 1'b0;
        reset_n = 1'b0;
        model_reset();
        #2;
        rd(2'd2, r); chk("rst_alert", {28'h0, r[3:0]}, 32'h0);
        chk("rst_alert_dp", {28'h0, dp_n}, 32'hE);
        @(negedge clk);
        reset_n = 1'b1;
        run(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
